trace_sequencer: RTL and testbench



---
 rtl/trace_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_trace_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_sequencer.sv
// trace_sequencer: walks a preloaded trace memory of {cmd[3:0], addr} entries
// and hands one command per valid/ready handshake to the cache model.
// Optional feature macro: TRACE_FILTER_EN. When it is defined, invalid command
// codes are skipped and counted. When it is undefined, every code except the
// end marker 4'hF is issued downstream, and bad_cmd_count reads as zero.
`timescale 1ns/1ps

`ifndef AddressBits
`define AddressBits 32
`endif

module trace_sequencer #(
  parameter int DEPTH_BITS  = 16,
  parameter int AddressBits = `AddressBits
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode_in,
  output logic                    mem_rd,
  output logic [DEPTH_BITS-1:0]   mem_addr,
  input  logic [AddressBits+3:0]  mem_rdata,
  output logic [3:0]              command,
  output logic [AddressBits-1:0]  address,
  output logic                    mode,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             bad_cmd_count
);

`ifdef TRACE_FILTER_EN
  localparam bit FilterEn = 1'b1;
`else
  localparam bit FilterEn = 1'b0;
`endif

  localparam logic [3:0] CmdEnd  = 4'hF;
  localparam logic [3:0] CmdIdle = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_FIN
  } state_e;

  state_e                   state_q;
  logic [DEPTH_BITS-1:0]    ptr_q;
  logic                     mem_rd_q;
  logic [DEPTH_BITS-1:0]    mem_addr_q;
  logic [3:0]               command_q;
  logic [AddressBits-1:0]   address_q;
  logic                     mode_q;
  logic                     cmd_valid_q;
  logic                     busy_q;
  logic                     done_q;
  logic [15:0]              bad_cnt_q;

  logic [3:0]               rd_cmd;
  logic [AddressBits-1:0]   rd_addr;
  logic                     ptr_last;
  logic [DEPTH_BITS-1:0]    ptr_d;
  logic [15:0]              bad_cnt_d;
  logic                     skip_cmd;

  // Codes the cache model understands; everything else is a trace defect.
  function automatic logic code_is_valid(input logic [3:0] code);
    case (code)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  assign rd_cmd    = mem_rdata[AddressBits+3:AddressBits];
  assign rd_addr   = mem_rdata[AddressBits-1:0];
  // The all-ones index is the terminal entry; the pointer never wraps.
  assign ptr_last  = &ptr_q;
  assign ptr_d     = ptr_q + 1'b1;
  assign bad_cnt_d = (&bad_cnt_q) ? bad_cnt_q : bad_cnt_q + 16'd1;
  assign skip_cmd  = FilterEn & ~code_is_valid(rd_cmd);

  // Sequencer FSM: every output is a register updated here.
  // NOTE: sequential state uses <= so all registers update together from
  // pre-edge values; a blocking = here would make later lines see new values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      command_q   <= CmdIdle;
      address_q   <= '0;
      mode_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bad_cnt_q   <= '0;
    end else begin
      // The read strobe is a single-cycle pulse unless a branch below re-arms it.
      mem_rd_q <= 1'b0;
      case (state_q)
        S_IDLE, S_FIN: begin
          if (start) begin
            state_q    <= S_FETCH;
            ptr_q      <= '0;
            bad_cnt_q  <= '0;
            done_q     <= 1'b0;
            mode_q     <= mode_in;
            busy_q     <= 1'b1;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= '0;
          end
        end

        S_FETCH: begin
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (rd_cmd == CmdEnd) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (skip_cmd) begin
            bad_cnt_q <= bad_cnt_d;
            if (ptr_last) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              ptr_q      <= ptr_d;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= ptr_d;
            end
          end else begin
            state_q     <= S_ISSUE;
            command_q   <= rd_cmd;
            address_q   <= rd_addr;
            cmd_valid_q <= 1'b1;
          end
        end

        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            command_q   <= CmdIdle;
            if (ptr_last) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              ptr_q      <= ptr_d;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= ptr_d;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd        = mem_rd_q;
  assign mem_addr      = mem_addr_q;
  assign command       = command_q;
  assign address       = address_q;
  assign mode          = mode_q;
  assign cmd_valid     = cmd_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign bad_cmd_count = FilterEn ? bad_cnt_q : 16'h0000;

endmodule

// File: tb/tb_trace_sequencer.sv
// Self-checking bench for trace_sequencer with a 4-entry trace memory.
// Directed table vectors, hand sequences for backpressure and reset, and
// randomized traces checked against a list-based reference model.
`timescale 1ns/1ps

module tb_trace_sequencer;

  localparam int DB   = 2;
  localparam int NENT = 1 << DB;
`ifdef TRACE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, mode_in, cmd_ready;
  logic          mem_rd;
  logic [DB-1:0] mem_addr;
  logic [35:0]   mem_rdata;
  logic [3:0]    command;
  logic [31:0]   address;
  logic          mode, cmd_valid, busy, done;
  logic [15:0]   bad_cmd_count;

  always #5 clk = ~clk;

  trace_sequencer #(.DEPTH_BITS(DB)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .command(command), .address(address), .mode(mode),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .busy(busy), .done(done), .bad_cmd_count(bad_cmd_count)
  );

  // Trace memory: data is available the cycle after the read strobe.
  logic [35:0] mem [NENT];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [35:0] exp_q[$];
  int exp_bad, exp_rd, exp_cyc;

  function automatic bit code_ok(input logic [3:0] c);
    return c inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9};
  endfunction

  // Walks the memory as a list: cost is 3 cycles per issued entry,
  // 2 per skipped entry and 2 for the end marker.
  task automatic model_run();
    logic [3:0] c;
    exp_q.delete(); exp_bad = 0; exp_rd = 0; exp_cyc = 0;
    for (int i = 0; i < NENT; i++) begin
      c = mem[i][35:32];
      exp_rd++;
      if (c == 4'hF) begin
        exp_cyc += 2;
        break;
      end
      if (FILT && !code_ok(c)) begin
        exp_bad++;
        exp_cyc += 2;
      end else begin
        exp_q.push_back(mem[i]);
        exp_cyc += 3;
      end
    end
  endtask

  // ---------------- run driver / monitor ----------------
  logic [35:0] obs_q[$];
  int obs_vk[$];
  int obs_rd, obs_done, obs_stalls, obs_first_rd;

  // Pulses start, then samples every falling edge; cycle k=1 is the one
  // right after the edge that captured start.
  task automatic run_trace(input bit rnd, input bit mode_v);
    logic [35:0] held;
    bit stalled;
    int proto_err;
    obs_q.delete(); obs_vk.delete();
    obs_rd = 0; obs_done = -1; obs_stalls = 0; obs_first_rd = -1;
    stalled = 1'b0; proto_err = 0; held = '0;
    @(negedge clk);
    start = 1'b1; mode_in = mode_v; cmd_ready = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start   = 1'b0;
      mode_in = ~mode_v;
      if (mode !== mode_v) proto_err++;
      if (mem_rd) begin
        if (mem_addr !== obs_rd[DB-1:0]) proto_err++;
        if (obs_first_rd < 0) obs_first_rd = k;
        obs_rd++;
      end
      if (stalled && (!cmd_valid || {command, address} !== held)) proto_err++;
      if (done) begin
        if (busy || cmd_valid || command !== 4'hF) proto_err++;
        obs_done = k;
        break;
      end
      if (!busy) proto_err++;
      // start while busy must be ignored
      start     = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cmd_valid && cmd_ready) begin
        obs_q.push_back({command, address});
        obs_vk.push_back(k);
      end
      stalled = cmd_valid && !cmd_ready;
      if (stalled) begin
        held = {command, address};
        obs_stalls++;
      end
    end
    start = 1'b0;
    check("protocol", proto_err, 0);
    check("done reached", obs_done, (obs_done < 0) ? 64'd0 : 64'(obs_done));
    if (obs_done < 0) check("run timeout", 0, 1);
  endtask

  task automatic compare(input string tag, input int dcyc);
    check({tag, " issued"}, obs_q.size(), exp_q.size());
    foreach (exp_q[j])
      if (j < obs_q.size()) check({tag, " entry"}, obs_q[j], exp_q[j]);
    check({tag, " bad"},  bad_cmd_count, exp_bad);
    check({tag, " reads"}, obs_rd, exp_rd);
    check({tag, " done cycle"}, obs_done, dcyc);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic [3:0][35:0] ent;
    logic [2:0]       n_iss;
    logic [3:0][35:0] iss;
    logic [2:0]       n_bad;
    logic [2:0]       n_rd;
    logic [4:0]       done_cyc;
  } vec_t;

  function automatic vec_t mk(input logic [35:0] e0, e1, e2, e3,
                              input int ni, input logic [35:0] i0, i1, i2, i3,
                              input int nb, input int nr, input int dc);
    vec_t v;
    v.ent[0] = e0; v.ent[1] = e1; v.ent[2] = e2; v.ent[3] = e3;
    v.n_iss  = 3'(ni);
    v.iss[0] = i0; v.iss[1] = i1; v.iss[2] = i2; v.iss[3] = i3;
    v.n_bad  = 3'(nb);
    v.n_rd   = 3'(nr);
    v.done_cyc = 5'(dc);
    return v;
  endfunction

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    // Table: ready tied high, expectations derived by hand.
    vecs[0] = mk(36'h0_00001000, 36'h1_00002000, 36'hF_00000000, 36'h0_00009999,
                 2, 36'h0_00001000, 36'h1_00002000, 36'h0, 36'h0, 0, 3, 9);
    vecs[1] = FILT ?
      mk(36'h5_00000011, 36'h7_00000022, 36'h4_00000040, 36'hF_00000000,
         1, 36'h4_00000040, 36'h0, 36'h0, 36'h0, 2, 4, 10) :
      mk(36'h5_00000011, 36'h7_00000022, 36'h4_00000040, 36'hF_00000000,
         3, 36'h5_00000011, 36'h7_00000022, 36'h4_00000040, 36'h0, 0, 4, 12);
    vecs[2] = FILT ?
      mk(36'hA_00000001, 36'hB_00000002, 36'hC_00000003, 36'hD_00000004,
         0, 36'h0, 36'h0, 36'h0, 36'h0, 4, 4, 9) :
      mk(36'hA_00000001, 36'hB_00000002, 36'hC_00000003, 36'hD_00000004,
         4, 36'hA_00000001, 36'hB_00000002, 36'hC_00000003, 36'hD_00000004, 0, 4, 13);
    // Runs straight from FIN after the previous vector: counter must clear.
    vecs[3] = mk(36'h0_0000000A, 36'h1_0000000B, 36'h8_0000000C, 36'h9_0000000D,
                 4, 36'h0_0000000A, 36'h1_0000000B, 36'h8_0000000C, 36'h9_0000000D, 0, 4, 13);
    vecs[4] = mk(36'hF_00000005, 36'h0_00000001, 36'h0_00000002, 36'h0_00000003,
                 0, 36'h0, 36'h0, 36'h0, 36'h0, 0, 1, 3);
    vecs[5] = FILT ?
      mk(36'h3_00000010, 36'h4_00000020, 36'h2_00000030, 36'h6_00000040,
         3, 36'h3_00000010, 36'h4_00000020, 36'h2_00000030, 36'h0, 1, 4, 12) :
      mk(36'h3_00000010, 36'h4_00000020, 36'h2_00000030, 36'h6_00000040,
         4, 36'h3_00000010, 36'h4_00000020, 36'h2_00000030, 36'h6_00000040, 0, 4, 13);

    // ---- reset state ----
    reset = 1'b1; start = 1'b0; mode_in = 1'b0; cmd_ready = 1'b0;
    for (int i = 0; i < NENT; i++) mem[i] = 36'hF_00000000;
    repeat (3) @(negedge clk);
    check("rst mem_rd", mem_rd, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst command", command, 4'hF);
    check("rst address", address, 0);
    check("rst mode", mode, 0);
    check("rst cmd_valid", cmd_valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst bad", bad_cmd_count, 0);
    reset = 1'b0;

    // ---- first-trace latency ----
    for (int i = 0; i < NENT; i++) mem[i] = vecs[0].ent[i];
    run_trace(1'b0, 1'b1);
    check("lat first mem_rd", obs_first_rd, 1);
    check("lat first valid", obs_vk[0], 3);
    check("lat second valid", obs_vk[1], 6);

    // ---- table vectors ----
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NENT; i++) mem[i] = vecs[v].ent[i];
      exp_q.delete();
      for (int j = 0; j < int'(vecs[v].n_iss); j++) exp_q.push_back(vecs[v].iss[j]);
      exp_bad = vecs[v].n_bad;
      exp_rd  = vecs[v].n_rd;
      run_trace(1'b0, v[0]);
      compare($sformatf("vec%0d", v), vecs[v].done_cyc);
    end
    repeat (2) @(negedge clk);
    check("done held", {done, busy, cmd_valid}, 3'b100);

    // ---- backpressure on a single entry ----
    mem[0] = 36'h2_0000ABCD; mem[1] = 36'hF_00000000;
    @(negedge clk); start = 1'b1; cmd_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 10 && !cmd_valid; n++) @(negedge clk);
    check("bp valid", cmd_valid, 1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp hold", {cmd_valid, mem_rd, mem_addr, command, address},
            {1'b1, 1'b0, 2'd0, 4'h2, 32'h0000ABCD});
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    check("bp accept", {cmd_valid, command, mem_rd, mem_addr}, {1'b0, 4'hF, 1'b1, 2'd1});
    for (int n = 0; n < 10 && !done; n++) @(negedge clk);
    check("bp done", done, 1);

    // ---- asynchronous reset while a command is pending ----
    mem[0] = 36'h3_00001234; mem[1] = 36'h1_00005678; mem[2] = 36'hF_00000000;
    @(negedge clk); start = 1'b1; cmd_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 10 && !cmd_valid; n++) @(negedge clk);
    check("ar in issue", cmd_valid, 1);
    #2 reset = 1'b1;
    #1 check("ar async", {cmd_valid, command, busy, done, address},
             {1'b0, 4'hF, 1'b0, 1'b0, 32'h0});
    @(negedge clk); reset = 1'b0;
    model_run();
    run_trace(1'b0, 1'b0);
    compare("ar rerun", 1 + exp_cyc);

    // ---- randomized traces ----
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NENT; i++)
        mem[i] = {4'($urandom_range(0, 15)), 32'($urandom)};
      model_run();
      run_trace(1'b1, 1'($urandom_range(0, 1)));
      compare($sformatf("rnd%0d", r), 1 + exp_cyc + obs_stalls);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
